// File: rtl/lzrw1_pkg.sv
// lzrw1_pkg: shared types and constants for the LZRW1 compressed stream parser.
//   parser_state_t : parser FSM states
//   item_t         : one decoded item (16-bit word + copy flag)
//   ITEMS_PER_GROUP: items selected by one control byte
//   LIT_PAD        : upper byte placed above a literal
package lzrw1_pkg;

   localparam int unsigned ITEMS_PER_GROUP = 8;
   localparam logic [7:0]  LIT_PAD         = 8'h00;

   typedef enum logic [2:0] {
      S_CTRL,
      S_LIT,
      S_HI,
      S_LO,
      S_OUT
   } parser_state_t;

   typedef struct packed {
      logic [15:0] word;
      logic        is_copy;
   } item_t;

endpackage

// File: rtl/compressed_stream_parser_if.sv
// compressed_stream_parser_if: byte-stream input and item output of the parser.
//   byte_in/byte_in_valid/byte_in_last/byte_in_ready : compressed byte handshake
//   data_out/control_word_out/data_out_valid         : item presented downstream
//   decompressor_busy                                : downstream back-pressure
//   stream_done/protocol_error                       : status
// Modports: master = feeder/decompressor side, slave = parser side.
interface compressed_stream_parser_if;

   logic [7:0]  byte_in;
   logic        byte_in_valid;
   logic        byte_in_last;
   logic        byte_in_ready;
   logic [15:0] data_out;
   logic        control_word_out;
   logic        data_out_valid;
   logic        decompressor_busy;
   logic        stream_done;
   logic        protocol_error;

   modport master (
      output byte_in,
      output byte_in_valid,
      output byte_in_last,
      input  byte_in_ready,
      input  data_out,
      input  control_word_out,
      input  data_out_valid,
      output decompressor_busy,
      input  stream_done,
      input  protocol_error
   );

   modport slave (
      input  byte_in,
      input  byte_in_valid,
      input  byte_in_last,
      output byte_in_ready,
      output data_out,
      output control_word_out,
      output data_out_valid,
      input  decompressor_busy,
      output stream_done,
      output protocol_error
   );

endinterface

// File: rtl/compressed_stream_stats.sv
// compressed_stream_stats: saturating literal/copy acceptance counters.
//   i_clock, i_reset      : clock, synchronous active-high reset
//   i_lit_accept          : a literal item was accepted this cycle
//   i_copy_accept         : a copy item was accepted this cycle
//   o_literal_count       : accepted literals, saturating
//   o_copy_count          : accepted copies, saturating
// Only instantiated when COMPRESSED_STREAM_PARSER_STATS_EN is defined.
module compressed_stream_stats #(
   parameter int unsigned STAT_WIDTH = 16
) (
   input  logic                  i_clock,
   input  logic                  i_reset,
   input  logic                  i_lit_accept,
   input  logic                  i_copy_accept,
   output logic [STAT_WIDTH-1:0] o_literal_count,
   output logic [STAT_WIDTH-1:0] o_copy_count
);

   logic [STAT_WIDTH-1:0] r_lit_cnt;
   logic [STAT_WIDTH-1:0] r_copy_cnt;

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_lit_cnt  <= '0;
         r_copy_cnt <= '0;
      end else begin
         if (i_lit_accept && (r_lit_cnt != '1)) begin
            r_lit_cnt <= r_lit_cnt + 1'b1;
         end
         if (i_copy_accept && (r_copy_cnt != '1)) begin
            r_copy_cnt <= r_copy_cnt + 1'b1;
         end
      end
   end

   assign o_literal_count = r_lit_cnt;
   assign o_copy_count    = r_copy_cnt;

endmodule

// File: rtl/compressed_stream_parser.sv
// compressed_stream_parser: splits a raw LZRW1 compressed byte stream into
// per-item words for decompressor_top, holding each item while it is busy.
//   clock, reset : clock, synchronous active-high reset
//   bus (slave)  : byte input handshake, item output handshake, status
//   literal_count, copy_count : optional saturating statistics, present only
//                 when COMPRESSED_STREAM_PARSER_STATS_EN is defined
// ITEMS_PER_GROUP must be 8 (control byte width).
module compressed_stream_parser #(
   parameter int unsigned ITEMS_PER_GROUP = 8,
   parameter int unsigned STAT_WIDTH      = 16
) (
   input  logic                        clock,
   input  logic                        reset,
   compressed_stream_parser_if.slave   bus
`ifdef COMPRESSED_STREAM_PARSER_STATS_EN
   ,
   output logic [STAT_WIDTH-1:0]       literal_count,
   output logic [STAT_WIDTH-1:0]       copy_count
`endif
);

   import lzrw1_pkg::*;

   localparam logic [2:0] LastIdx = 3'(ITEMS_PER_GROUP - 1);

   parser_state_t r_state, w_state_d;
   logic [6:0]    r_ctrl, w_ctrl_d;       // bit 7 is consumed directly at latch time
   logic [2:0]    r_bit_idx, w_bit_idx_d;
   item_t         r_item, w_item_d;
   logic          r_last, w_last_d;       // last flag travelling with the held item
   logic          r_err, w_err_d;
   logic          r_done, w_done_d;

   logic          w_ready;
   logic          w_xfer;
   logic          w_accept;

   // Gated by reset so ready reads 0 while reset is held.
   assign w_ready  = !reset && (r_state inside {S_CTRL, S_LIT, S_HI, S_LO});
   assign w_xfer   = bus.byte_in_valid && w_ready;
   assign w_accept = (r_state == S_OUT) && !bus.decompressor_busy;

   always_comb begin
      w_state_d   = r_state;
      w_ctrl_d    = r_ctrl;
      w_bit_idx_d = r_bit_idx;
      w_item_d    = r_item;
      w_last_d    = r_last;
      w_err_d     = r_err;
      w_done_d    = 1'b0;
      unique case (r_state)
         S_CTRL: begin
            if (w_xfer) begin
               w_ctrl_d    = bus.byte_in[6:0];
               w_bit_idx_d = 3'd0;
               if (bus.byte_in_last) begin
                  // Empty group ends the stream.
                  w_done_d  = 1'b1;
                  w_state_d = S_CTRL;
               end else begin
                  w_state_d = bus.byte_in[7] ? S_HI : S_LIT;
               end
            end
         end
         S_LIT: begin
            if (w_xfer) begin
               w_item_d.word    = {LIT_PAD, bus.byte_in};
               w_item_d.is_copy = 1'b0;
               w_last_d         = bus.byte_in_last;
               w_state_d        = S_OUT;
            end
         end
         S_HI: begin
            if (w_xfer) begin
               w_item_d.word[15:8] = bus.byte_in;
               if (bus.byte_in_last) begin
                  // Stream ended between the two bytes of a copy.
                  w_err_d   = 1'b1;
                  w_state_d = S_CTRL;
               end else begin
                  w_state_d = S_LO;
               end
            end
         end
         S_LO: begin
            if (w_xfer) begin
               w_item_d.word[7:0] = bus.byte_in;
               w_item_d.is_copy   = 1'b1;
               w_last_d           = bus.byte_in_last;
               w_state_d          = S_OUT;
            end
         end
         S_OUT: begin
            if (w_accept) begin
               if (r_last) begin
                  w_done_d  = 1'b1;
                  w_state_d = S_CTRL;
               end else if (r_bit_idx == LastIdx) begin
                  w_state_d = S_CTRL;
               end else begin
                  w_bit_idx_d = r_bit_idx + 3'd1;
                  // Next item's flag: ctrl bit (6 - bit_idx) of the stored bits 6..0.
                  w_state_d   = r_ctrl[3'd6 - r_bit_idx] ? S_HI : S_LIT;
               end
            end
         end
         default: w_state_d = S_CTRL;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state   <= S_CTRL;
         r_ctrl    <= '0;
         r_bit_idx <= '0;
         r_item    <= '0;
         r_last    <= 1'b0;
         r_err     <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_state   <= w_state_d;
         r_ctrl    <= w_ctrl_d;
         r_bit_idx <= w_bit_idx_d;
         r_item    <= w_item_d;
         r_last    <= w_last_d;
         r_err     <= w_err_d;
         r_done    <= w_done_d;
      end
   end

   assign bus.byte_in_ready    = w_ready;
   assign bus.data_out         = r_item.word;
   assign bus.control_word_out = r_item.is_copy;
   assign bus.data_out_valid   = (r_state == S_OUT);
   assign bus.stream_done      = r_done;
   assign bus.protocol_error   = r_err;

`ifdef COMPRESSED_STREAM_PARSER_STATS_EN
   logic w_lit_accept;
   logic w_copy_accept;

   assign w_lit_accept  = w_accept && !r_item.is_copy;
   assign w_copy_accept = w_accept && r_item.is_copy;

   compressed_stream_stats #(
      .STAT_WIDTH (STAT_WIDTH)
   ) u_stats (
      .i_clock         (clock),
      .i_reset         (reset),
      .i_lit_accept    (w_lit_accept),
      .i_copy_accept   (w_copy_accept),
      .o_literal_count (literal_count),
      .o_copy_count    (copy_count)
   );
`endif

endmodule

// File: doc/compressed_stream_parser.md
Name: compressed_stream_parser

Overview:
- Upstream neighbour of decompressor_top.
- Accepts the raw LZRW1 compressed byte stream: a control byte, then up to 8 items, then the next control byte, and so on.
- Splits the stream into per-item words: {data_in[15:0], control_word_in, data_in_valid}.
- Holds each item until decompressor_top is not busy.
- Replaces the bench-side feeder logic in hardware.

Parameters:
- ITEMS_PER_GROUP, 8, items per control byte (control byte width); must be 8.
- STAT_WIDTH, 16, width of the optional statistics counters.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous active-high reset
- byte_in  in  8  compressed stream byte
- byte_in_valid  in  1  byte_in is valid
- byte_in_last  in  1  byte_in is the final byte of the stream
- byte_in_ready  out  1  parser takes byte_in this cycle
- data_out  out  16  item word; drives decompressor data_in
- control_word_out  out  1  1 = copy item (2 bytes), 0 = literal; drives control_word_in
- data_out_valid  out  1  item presented; drives data_in_valid
- decompressor_busy  in  1  busy from decompressor_top
- stream_done  out  1  one-cycle pulse after the last item is accepted
- protocol_error  out  1  sticky; stream ended mid-item

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high, sampled on the rising edge of clock.
- Reset values: byte_in_ready=0, data_out=16'h0000, control_word_out=0, data_out_valid=0, stream_done=0, protocol_error=0, state=S_CTRL, bit_idx=0.
- Byte handshake: a byte transfers on a rising edge where byte_in_valid && byte_in_ready.
- byte_in_ready is 1 only in S_CTRL, S_LIT, S_HI and S_LO.
- Item handshake: an item is accepted on a rising edge where data_out_valid && !decompressor_busy.
- data_out, control_word_out and data_out_valid hold stable until the item is accepted.
- Control byte bit order: MSB first; bit 7 selects item 0, bit 0 selects item 7.
- States:
  - S_CTRL: on transfer, latch ctrl_reg=byte_in, bit_idx=0. Then go to S_HI if byte_in[7]=1, else S_LIT. If byte_in_last, raise stream_done (empty group) and return to S_CTRL.
  - S_LIT: on transfer, data_out={8'h00, byte_in}, control_word_out=0, go to S_OUT.
  - S_HI: on transfer, data_out[15:8]=byte_in, go to S_LO. If byte_in_last, set protocol_error and go to S_CTRL.
  - S_LO: on transfer, data_out[7:0]=byte_in, control_word_out=1, go to S_OUT.
  - S_OUT: data_out_valid=1. On acceptance:
    - If the item's byte was last: pulse stream_done and go to S_CTRL.
    - Else if bit_idx==7: go to S_CTRL.
    - Else: bit_idx++ and go to S_HI or S_LIT per ctrl_reg[6-bit_idx].
- A last flag is captured with each item byte; the stream ends after that item even if group bits remain.
- Latency:
  - Literal: byte transferred at edge N gives data_out_valid=1 from N+1.
  - Copy: second byte transferred at edge N gives data_out_valid=1 from N+1.
  - Minimum 2 cycles per literal, 3 per copy, +1 per control byte.
- data_out_valid drops the cycle after acceptance.
- No overlap: byte_in_ready=0 while in S_OUT.
- decompressor_busy held high: the parser stalls indefinitely in S_OUT with no data loss.
- protocol_error clears only on reset.
- Reset mid-item: the partial item is discarded and the parser returns to S_CTRL.
- bit_idx is 3 bits and wraps only through the S_CTRL transition.

Optional Feature:
- Macro: COMPRESSED_STREAM_PARSER_STATS_EN.
- When defined, adds outputs literal_count[STAT_WIDTH-1:0] and copy_count[STAT_WIDTH-1:0].
- Each counter increments on acceptance of its item type, saturates at all-ones, and clears on reset.
- When undefined, these ports and counters do not exist and behaviour is otherwise identical.

Decomposition:
- lzrw1_pkg holds:
  - parser_state_t enum (S_CTRL, S_LIT, S_HI, S_LO, S_OUT)
  - item_t struct {logic [15:0] word; logic is_copy;}
  - ITEMS_PER_GROUP constant
  - LIT_PAD = 8'h00 constant
- One sub-module, compressed_stream_stats, holds the saturating counters and is instantiated only under the macro.
- The FSM stays in the parent.

Test Plan:
- Literal group: stream 8'h00 then 'a','b','c' (last on 'c'), busy=0.
  - Expect items 16'h0061, 16'h0062, 16'h0063, all with control_word_out=0.
  - Expect stream_done one cycle after the 3rd acceptance.
- Mixed group: ctrl 8'h40, then 'x', then 8'h12,8'h34, then 'y' (last).
  - Expect 16'h0078/0, 16'h1234/1, 16'h0079/0.
- Back-pressure: hold busy=1 for 10 cycles during item 16'h1234.
  - Expect data_out stable, byte_in_ready=0, and exactly one acceptance when busy falls.
- Group rollover: 8'h00 + 8 literals, then 8'hFF + 2 copies (last).
  - Expect 10 items; the second control byte is consumed only after item 7 is accepted.
- Truncated copy: ctrl 8'h80, byte 8'hAB with last=1.
  - Expect protocol_error=1 and no data_out_valid.
  - Expect protocol_error to stay 1 until reset.
- Reset mid-copy, then a fresh stream 8'h00,'z'(last).
  - Expect a single item 16'h007A.
  - With COMPRESSED_STREAM_PARSER_STATS_EN: literal_count=1, copy_count=0.
